// File: rtl/issue_scheduler.sv
// Tomasulo issue controller: owns ROB head/tail/count and per-class RS occupancy.
// Optional stall statistic enabled by defining STALL_STATS_EN.
module issue_scheduler #(
  parameter int ROB_DEPTH = 8,
  parameter int ROB_AW    = 3,
  parameter int RS_DEPTH  = 3
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_func,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  output logic              iss_valid,
  output logic [1:0]        iss_class,
  output logic [ROB_AW-1:0] iss_tag,
  output logic [1:0]        iss_slot,
  output logic [3:0]        iss_func,
  output logic [3:0]        iss_rd,
  output logic [3:0]        iss_rs1,
  output logic [3:0]        iss_rs2,
  input  logic              rs_free,
  input  logic [1:0]        rs_free_class,
  input  logic [1:0]        rs_free_slot,
  input  logic              commit,
  input  logic              flush,
  output logic [ROB_AW-1:0] rob_head,
  output logic [ROB_AW-1:0] rob_tail,
  output logic [ROB_AW:0]   rob_count,
  output logic              rob_full,
  output logic              rob_empty,
  output logic [1:0]        add_count,
  output logic [1:0]        mul_count,
  output logic [1:0]        bch_count,
  output logic [15:0]       stall_cycles
);

  logic [ROB_AW-1:0]   head, tail;
  logic [ROB_AW:0]     count;
  logic [RS_DEPTH-1:0] add_map, mul_map, bch_map;
  logic [RS_DEPTH-1:0] cls_map, free_mask, acc_mask;
  logic [1:0]          in_class, acc_slot;
  logic                accept, commit_ok;

  function automatic logic [1:0] first_free(input logic [RS_DEPTH-1:0] map);
    logic [1:0] s;
    s = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (!map[i]) s = i[1:0];
    return s;
  endfunction

  function automatic logic [1:0] pop(input logic [RS_DEPTH-1:0] map);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < RS_DEPTH; i++) n = n + {2'b00, map[i]};
    return n[1:0];
  endfunction

  always_comb begin
    in_class = in_func[3] ? (in_func[2] ? 2'd2 : 2'd1) : 2'd0;
    case (in_class)
      2'd0:    cls_map = add_map;
      2'd1:    cls_map = mul_map;
      default: cls_map = bch_map;
    endcase
  end

  assign rob_full  = (count == (ROB_AW+1)'(ROB_DEPTH));
  assign rob_empty = (count == '0);

  // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered state and in_func, never on in_valid.
  assign in_ready  = !rst && !rob_full && !(&cls_map);
  assign accept    = in_valid && in_ready;
  assign commit_ok = commit && !rob_empty;
  assign acc_slot  = first_free(cls_map);

  // Out-of-range slot indices match no bit, so they are dropped here.
  always_comb begin
    free_mask = '0;
    acc_mask  = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      free_mask[i] = rs_free && (rs_free_slot == i[1:0]);
      acc_mask[i]  = accept && (acc_slot == i[1:0]);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      add_map   <= '0;
      mul_map   <= '0;
      bch_map   <= '0;
      iss_valid <= 1'b0;
      iss_class <= '0;
      iss_tag   <= '0;
      iss_slot  <= '0;
      iss_func  <= '0;
      iss_rd    <= '0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      add_map   <= '0;
      mul_map   <= '0;
      bch_map   <= '0;
      iss_valid <= 1'b0;
    end else begin
      if (accept) tail <= tail + 1'b1;
      if (commit_ok) head <= head + 1'b1;
      if (accept && !commit_ok) count <= count + 1'b1;
      else if (!accept && commit_ok) count <= count - 1'b1;
      add_map <= (add_map & ~((rs_free_class == 2'd0) ? free_mask : '0))
               | ((in_class == 2'd0) ? acc_mask : '0);
      mul_map <= (mul_map & ~((rs_free_class == 2'd1) ? free_mask : '0))
               | ((in_class == 2'd1) ? acc_mask : '0);
      bch_map <= (bch_map & ~((rs_free_class == 2'd2) ? free_mask : '0))
               | ((in_class == 2'd2) ? acc_mask : '0);
      iss_valid <= accept;
      if (accept) begin
        iss_class <= in_class;
        iss_tag   <= tail;
        iss_slot  <= acc_slot;
        iss_func  <= in_func;
        iss_rd    <= in_rd;
        iss_rs1   <= in_rs1;
        iss_rs2   <= in_rs2;
      end
    end
  end

  assign rob_head  = head;
  assign rob_tail  = tail;
  assign rob_count = count;
  assign add_count = pop(add_map);
  assign mul_count = pop(mul_map);
  assign bch_count = pop(bch_map);

`ifdef STALL_STATS_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk1) begin
    if (rst || flush) stall_q <= '0;
    else if (in_valid && !in_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule
